// File: rtl/if_id_hazard_stage.sv
// IF/ID pipeline register with load-use stall and redirect flush control.
// All state updates on the falling clock edge, aligned with the pipeline registers.
module if_id_hazard_stage #(
    parameter int NBits     = 32,
    parameter int CountBits = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NBits-1:0] in_PC_4,
    input  logic [NBits-1:0] in_Instruction,
    input  logic             in_EX_CtrlMemRead,
    input  logic [4:0]       in_EX_WriteRegister,
    input  logic             in_BranchTaken,
    input  logic             in_JumpTaken,
    output logic [NBits-1:0] out_PC_4,
    output logic [NBits-1:0] out_Instruction,
    output logic             out_PCWrite,
    output logic             out_IDEX_Flush,
    output logic             out_Stalled,
    output logic [15:0]      out_StallCount,
    output logic [15:0]      out_FlushCount,
    output logic [1:0]       out_State
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        LD_HOLD = 2'd0,
        LD_IN   = 2'd1,
        LD_NOP  = 2'd2
    } load_t;

    localparam logic [CountBits-1:0] CountMax = {CountBits{1'b1}};

    state_t               state_q;
    state_t               state_d;
    load_t                load_sel;
    logic [NBits-1:0]     pc_4_q;
    logic [NBits-1:0]     instr_q;
    logic [CountBits-1:0] stall_cnt_q;
    logic [CountBits-1:0] flush_cnt_q;
    logic [4:0]           rs;
    logic [4:0]           rt;
    logic                 hazard;
    logic                 redirect;
    logic                 pc_write;
    logic                 idex_flush;
    logic                 stall_inc;
    logic                 flush_inc;

    assign rs       = instr_q[25:21];
    assign rt       = instr_q[20:16];
    assign hazard   = in_EX_CtrlMemRead && (in_EX_WriteRegister != 5'd0) &&
                      ((in_EX_WriteRegister == rs) || (in_EX_WriteRegister == rt));
    assign redirect = in_BranchTaken || in_JumpTaken;

    // Redirect beats hazard in every state; a stall never chains into another stall.
    always_comb begin
        pc_write   = 1'b0;
        idex_flush = 1'b1;
        load_sel   = LD_HOLD;
        state_d    = RUN;
        if (!reset) begin
            pc_write   = 1'b0;
            idex_flush = 1'b1;
            load_sel   = LD_NOP;
            state_d    = RUN;
        end else if (redirect) begin
            pc_write   = 1'b1;
            idex_flush = 1'b1;
            load_sel   = LD_NOP;
            state_d    = FLUSH;
        end else if (state_q == STALL) begin
            pc_write   = 1'b1;
            idex_flush = 1'b0;
            load_sel   = LD_IN;
            state_d    = RUN;
        end else if (hazard) begin
            pc_write   = 1'b0;
            idex_flush = 1'b1;
            load_sel   = LD_HOLD;
            state_d    = STALL;
        end else begin
            pc_write   = 1'b1;
            idex_flush = 1'b0;
            load_sel   = LD_IN;
            state_d    = RUN;
        end
    end

    assign stall_inc = reset && (state_q != STALL) && (state_d == STALL);
    assign flush_inc = reset && redirect;

    always_ff @(negedge clk) begin
        if (!reset) begin
            state_q     <= RUN;
            pc_4_q      <= '0;
            instr_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            case (load_sel)
                LD_IN: begin
                    pc_4_q  <= in_PC_4;
                    instr_q <= in_Instruction;
                end
                LD_NOP: begin
                    pc_4_q  <= '0;
                    instr_q <= '0;
                end
                default: begin
                    pc_4_q  <= pc_4_q;
                    instr_q <= instr_q;
                end
            endcase
            if (stall_inc && (stall_cnt_q != CountMax)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (flush_inc && (flush_cnt_q != CountMax)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign out_PC_4        = pc_4_q;
    assign out_Instruction = instr_q;
    assign out_PCWrite     = pc_write;
    assign out_IDEX_Flush  = idex_flush;
    assign out_Stalled     = reset && (state_q == STALL);
    assign out_StallCount  = 16'(stall_cnt_q);
    assign out_FlushCount  = 16'(flush_cnt_q);
    assign out_State       = state_q;

endmodule

// File: tb/tb_if_id_hazard_stage.sv
// Directed bench for if_id_hazard_stage: falling-edge pipeline register with stall/flush FSM.
// Counters are built narrow here so saturation is reachable in a short run.
module tb_if_id_hazard_stage;

    localparam int          NBITS    = 32;
    localparam int          CNT_BITS = 8;
    localparam logic [31:0] CNT_MAX  = 32'd255;
    localparam logic [31:0] S_RUN    = 32'd0;
    localparam logic [31:0] S_STALL  = 32'd1;
    localparam logic [31:0] S_FLUSH  = 32'd2;
    localparam logic [31:0] ADD_INSN = 32'h01095020;

    logic             clk;
    logic             reset;
    logic [NBITS-1:0] in_pc_4;
    logic [NBITS-1:0] in_instr;
    logic             ex_mem_read;
    logic [4:0]       ex_write_reg;
    logic             branch_taken;
    logic             jump_taken;
    logic [NBITS-1:0] out_pc_4;
    logic [NBITS-1:0] out_instr;
    logic             pc_write;
    logic             idex_flush;
    logic             stalled;
    logic [15:0]      stall_count;
    logic [15:0]      flush_count;
    logic [1:0]       state;

    int checks   = 0;
    int failures = 0;

    if_id_hazard_stage #(
        .NBits     (NBITS),
        .CountBits (CNT_BITS)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .in_PC_4             (in_pc_4),
        .in_Instruction      (in_instr),
        .in_EX_CtrlMemRead   (ex_mem_read),
        .in_EX_WriteRegister (ex_write_reg),
        .in_BranchTaken      (branch_taken),
        .in_JumpTaken        (jump_taken),
        .out_PC_4            (out_pc_4),
        .out_Instruction     (out_instr),
        .out_PCWrite         (pc_write),
        .out_IDEX_Flush      (idex_flush),
        .out_Stalled         (stalled),
        .out_StallCount      (stall_count),
        .out_FlushCount      (flush_count),
        .out_State           (state)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Active edge is the falling one; sample 1ns after it.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] ins, input logic mr,
                         input logic [4:0] wr, input logic br, input logic jp);
        in_pc_4      = pc;
        in_instr     = ins;
        ex_mem_read  = mr;
        ex_write_reg = wr;
        branch_taken = br;
        jump_taken   = jp;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
        step();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        drive(32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);

        // Reset values and reset-time control outputs.
        check("rst_pcwrite", 32'(pc_write), 32'd0);
        check("rst_flush", 32'(idex_flush), 32'd1);
        check("rst_stalled", 32'(stalled), 32'd0);
        step();
        check("rst_pc4", out_pc_4, 32'h0);
        check("rst_instr", out_instr, 32'h0);
        check("rst_state", 32'(state), S_RUN);
        check("rst_scnt", 32'(stall_count), 32'd0);
        check("rst_fcnt", 32'(flush_count), 32'd0);

        // First edge after release loads normally.
        reset = 1'b1;
        drive(32'h100, ADD_INSN, 1'b0, 5'd0, 1'b0, 1'b0);
        check("run_pcwrite", 32'(pc_write), 32'd1);
        check("run_flush", 32'(idex_flush), 32'd0);
        step();
        check("load_pc4", out_pc_4, 32'h100);
        check("load_instr", out_instr, ADD_INSN);

        // Load-use on rs ($8): one-cycle stall, IF/ID held.
        drive(32'h104, 32'h12345678, 1'b1, 5'd8, 1'b0, 1'b0);
        check("lu_pcwrite", 32'(pc_write), 32'd0);
        check("lu_flush", 32'(idex_flush), 32'd1);
        step();
        check("lu_stalled", 32'(stalled), 32'd1);
        check("lu_state", 32'(state), S_STALL);
        check("lu_hold_instr", out_instr, ADD_INSN);
        check("lu_hold_pc4", out_pc_4, 32'h100);
        check("lu_scnt", 32'(stall_count), 32'd1);
        check("st_pcwrite", 32'(pc_write), 32'd1);
        check("st_flush", 32'(idex_flush), 32'd0);
        step();
        check("st_back_run", 32'(state), S_RUN);
        check("st_stalled0", 32'(stalled), 32'd0);
        check("st_load_instr", out_instr, 32'h12345678);
        check("st_load_pc4", out_pc_4, 32'h104);
        check("st_scnt", 32'(stall_count), 32'd1);

        // rt match and no-MemRead cases.
        drive(32'h108, ADD_INSN, 1'b0, 5'd0, 1'b0, 1'b0);
        step();
        drive(32'h10c, ADD_INSN, 1'b1, 5'd9, 1'b0, 1'b0);
        check("rt_pcwrite", 32'(pc_write), 32'd0);
        check("rt_flush", 32'(idex_flush), 32'd1);
        drive(32'h10c, ADD_INSN, 1'b0, 5'd8, 1'b0, 1'b0);
        check("nomr_pcwrite", 32'(pc_write), 32'd1);
        check("nomr_flush", 32'(idex_flush), 32'd0);
        drive(32'h10c, ADD_INSN, 1'b1, 5'd10, 1'b0, 1'b0);
        check("other_reg_pcwrite", 32'(pc_write), 32'd1);

        // No hazard through $0.
        drive(32'h200, 32'h00005020, 1'b0, 5'd0, 1'b0, 1'b0);
        step();
        drive(32'h204, 32'h00005020, 1'b1, 5'd0, 1'b0, 1'b0);
        check("zero_pcwrite", 32'(pc_write), 32'd1);
        check("zero_flush", 32'(idex_flush), 32'd0);
        step();
        check("zero_stalled", 32'(stalled), 32'd0);
        check("zero_state", 32'(state), S_RUN);

        // Branch and hazard together: redirect wins.
        do_reset();
        drive(32'h300, ADD_INSN, 1'b0, 5'd0, 1'b0, 1'b0);
        step();
        drive(32'h304, 32'h22222222, 1'b1, 5'd8, 1'b1, 1'b0);
        check("sim_flush", 32'(idex_flush), 32'd1);
        check("sim_pcwrite", 32'(pc_write), 32'd1);
        step();
        check("sim_instr", out_instr, 32'h0);
        check("sim_pc4", out_pc_4, 32'h0);
        check("sim_fcnt", 32'(flush_count), 32'd1);
        check("sim_scnt", 32'(stall_count), 32'd0);
        check("sim_state", 32'(state), S_FLUSH);

        // Three back-to-back jumps.
        do_reset();
        drive(32'h400, 32'h33333333, 1'b0, 5'd0, 1'b0, 1'b0);
        step();
        for (int i = 1; i <= 3; i++) begin
            drive(32'h404 + 32'(i), 32'h44444444, 1'b0, 5'd0, 1'b0, 1'b1);
            step();
            check("jmp_state", 32'(state), S_FLUSH);
            check("jmp_instr", out_instr, 32'h0);
            check("jmp_fcnt", 32'(flush_count), 32'(i));
        end
        drive(32'h500, 32'h55555555, 1'b0, 5'd0, 1'b0, 1'b0);
        step();
        check("jmp_exit_state", 32'(state), S_RUN);
        check("jmp_exit_instr", out_instr, 32'h55555555);

        // Reset during STALL.
        do_reset();
        drive(32'h600, ADD_INSN, 1'b0, 5'd0, 1'b0, 1'b0);
        step();
        drive(32'h604, 32'h66666666, 1'b1, 5'd8, 1'b0, 1'b0);
        step();
        check("rs_in_stall", 32'(state), S_STALL);
        reset = 1'b0;
        #1;
        check("rs_stalled_low", 32'(stalled), 32'd0);
        check("rs_pcwrite", 32'(pc_write), 32'd0);
        check("rs_flush", 32'(idex_flush), 32'd1);
        step();
        check("rs_state", 32'(state), S_RUN);
        check("rs_instr", out_instr, 32'h0);
        check("rs_scnt", 32'(stall_count), 32'd0);
        check("rs_fcnt", 32'(flush_count), 32'd0);
        reset = 1'b1;

        // Reset during FLUSH with a redirect still asserted: no count.
        drive(32'h700, 32'h77777777, 1'b0, 5'd0, 1'b1, 1'b0);
        step();
        check("rf_in_flush", 32'(state), S_FLUSH);
        reset = 1'b0;
        #1;
        step();
        check("rf_state", 32'(state), S_RUN);
        check("rf_fcnt", 32'(flush_count), 32'd0);
        reset = 1'b1;

        // Saturation: hazard held, FSM alternates RUN/STALL.
        do_reset();
        drive(32'h800, ADD_INSN, 1'b1, 5'd8, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 2 * 255; i++) step();
        check("sat_reach", 32'(stall_count), CNT_MAX);
        for (int i = 0; i < 20; i++) step();
        check("sat_hold", 32'(stall_count), CNT_MAX);
        check("sat_fcnt", 32'(flush_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
